// File: rtl/mpc_memctl_pkg.sv
// Shared types and constants for the MPC memory controller.
package mpc_memctl_pkg;

   localparam int CL_WIDTH       = 256;
   localparam int MEM_DATA_WIDTH = 64;
   localparam int NLINE_WIDTH    = 5;
   localparam int QUEUE_DEPTH    = 4;

   localparam int BEATS  = CL_WIDTH / MEM_DATA_WIDTH;
   localparam int BEAT_W = $clog2(BEATS);

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   localparam logic [2:0] MEM_OP_LOAD = 3'h0;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      COLLECT,
      REFILL
   } mpc_memctl_state_e;

   // One queued linefill: line id plus already line-aligned address.
   typedef struct packed {
      logic [NLINE_WIDTH-1:0] id;
      logic [31:0]            addr;
   } memctl_req_t;

   // Clear the byte-offset bits so the address points at the start of a line.
   function automatic logic [31:0] line_align(input logic [31:0] addr);
      return addr & ~(32'(CL_WIDTH / 8) - 32'd1);
   endfunction

endpackage

// File: rtl/mpc_memctl_fifo.sv
// Small synchronous FIFO; full/empty derived from pointers with a wrap bit.
module mpc_memctl_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_data = mem[rd_ptr[AW-1:0]];

   // Pointer update; only the pointers carry reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Entry storage write.
   // NOTE: storage has no reset; an entry is only read after it was written,
   // so clearing it would cost flops for no behavioural gain.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/mpc_memctl.sv
// Linefill memory controller: queues requests, issues one line read at a
// time, assembles the returned beats and hands the line to the refill path.
module mpc_memctl
   import mpc_memctl_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      u_memctl_valid,
   output logic                      u_memctl_ready,
   input  logic [2:0]                u_memctl_op,
   input  logic [NLINE_WIDTH-1:0]    u_memctl_id,
   input  logic [31:0]               u_memctl_addr,
   output logic                      d_mem_req_valid,
   input  logic                      d_mem_req_ready,
   output logic [31:0]               d_mem_req_addr,
   input  logic                      d_mem_rsp_valid,
   output logic                      d_mem_rsp_ready,
   input  logic [MEM_DATA_WIDTH-1:0] d_mem_rsp_data,
   input  logic                      d_mem_rsp_last,
   output logic                      d_refill_valid,
   input  logic                      d_refill_ready,
   output logic [NLINE_WIDTH-1:0]    d_refill_id,
   output logic [CL_WIDTH-1:0]       d_refill_data,
   output logic                      err_valid
);

   mpc_memctl_state_e      state_q, state_d;
   memctl_req_t            push_req;
   memctl_req_t            head_req;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   fifo_pop;
   logic                   push_hs;
   logic                   load_op;
   logic                   beat_hs;
   logic                   beat_final;
   logic                   beat_err;
   logic [NLINE_WIDTH-1:0] id_q;
   logic [31:0]            addr_q;
   logic [BEAT_W-1:0]      beat_cnt_q;
   logic [CL_WIDTH-1:0]    line_q;
   logic                   err_q;

   assign load_op        = (u_memctl_op == MEM_OP_LOAD);
   assign u_memctl_ready = ~fifo_full;
   assign push_hs        = u_memctl_valid & u_memctl_ready;
   assign push_req       = '{id: u_memctl_id, addr: line_align(u_memctl_addr)};

   mpc_memctl_fifo #(
      .WIDTH ($bits(memctl_req_t)),
      .DEPTH (QUEUE_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_hs & load_op),
      .push_data (push_req),
      .pop       (fifo_pop),
      .pop_data  (head_req),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // All channel valids/readies come straight from the state register.
   assign d_mem_req_valid = (state_q == REQ);
   assign d_mem_rsp_ready = (state_q == COLLECT);
   assign d_refill_valid  = (state_q == REFILL);
   assign d_mem_req_addr  = addr_q;
   assign d_refill_id     = id_q;
   assign d_refill_data   = line_q;
   assign err_valid       = err_q;

   assign beat_hs    = d_mem_rsp_valid & d_mem_rsp_ready;
   assign beat_final = (beat_cnt_q == LAST_BEAT);
   // A beat ends the line when it is the last slot or carries last; the two
   // must agree, otherwise the transfer was malformed.
   assign beat_err   = beat_hs & (d_mem_rsp_last ^ beat_final);

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state and queue pop decision.
   // NOTE: defaults are assigned first so no path leaves an output unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_d  = state_q;
      fifo_pop = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               state_d  = REQ;
            end
         end
         REQ:     if (d_mem_req_ready) state_d = COLLECT;
         COLLECT: if (beat_hs && (beat_final || d_mem_rsp_last)) state_d = REFILL;
         REFILL:  if (d_refill_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Working registers: transaction id/address, beat counter, line buffer, error pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_q       <= '0;
         addr_q     <= '0;
         beat_cnt_q <= '0;
         line_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         if (fifo_pop) begin
            id_q       <= head_req.id;
            addr_q     <= head_req.addr;
            beat_cnt_q <= '0;
            line_q     <= '0;
         end else if (beat_hs) begin
            line_q[beat_cnt_q*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] <= d_mem_rsp_data;
            beat_cnt_q <= beat_cnt_q + 1'b1;
         end
         err_q <= (push_hs & ~load_op) | beat_err;
      end
   end

endmodule

// File: tb/tb_mpc_memctl.sv
// Self-checking bench for mpc_memctl: transaction-level scoreboard with
// randomized handshakes plus directed scenarios.
module tb_mpc_memctl;
   import mpc_memctl_pkg::*;

   logic                      clk = 1'b0;
   logic                      rst_n = 1'b0;
   logic                      u_memctl_valid = 1'b0;
   logic                      u_memctl_ready;
   logic [2:0]                u_memctl_op = '0;
   logic [NLINE_WIDTH-1:0]    u_memctl_id = '0;
   logic [31:0]               u_memctl_addr = '0;
   logic                      d_mem_req_valid;
   logic                      d_mem_req_ready = 1'b0;
   logic [31:0]               d_mem_req_addr;
   logic                      d_mem_rsp_valid = 1'b0;
   logic                      d_mem_rsp_ready;
   logic [MEM_DATA_WIDTH-1:0] d_mem_rsp_data = '0;
   logic                      d_mem_rsp_last = 1'b0;
   logic                      d_refill_valid;
   logic                      d_refill_ready = 1'b0;
   logic [NLINE_WIDTH-1:0]    d_refill_id;
   logic [CL_WIDTH-1:0]       d_refill_data;
   logic                      err_valid;

   always #5 clk = ~clk;

   mpc_memctl dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .u_memctl_valid  (u_memctl_valid),
      .u_memctl_ready  (u_memctl_ready),
      .u_memctl_op     (u_memctl_op),
      .u_memctl_id     (u_memctl_id),
      .u_memctl_addr   (u_memctl_addr),
      .d_mem_req_valid (d_mem_req_valid),
      .d_mem_req_ready (d_mem_req_ready),
      .d_mem_req_addr  (d_mem_req_addr),
      .d_mem_rsp_valid (d_mem_rsp_valid),
      .d_mem_rsp_ready (d_mem_rsp_ready),
      .d_mem_rsp_data  (d_mem_rsp_data),
      .d_mem_rsp_last  (d_mem_rsp_last),
      .d_refill_valid  (d_refill_valid),
      .d_refill_ready  (d_refill_ready),
      .d_refill_id     (d_refill_id),
      .d_refill_data   (d_refill_data),
      .err_valid       (err_valid)
   );

   typedef struct {
      logic [2:0]             op;
      logic [NLINE_WIDTH-1:0] id;
      logic [31:0]            addr;
   } stim_t;

   typedef struct {
      logic [NLINE_WIDTH-1:0] id;
      logic [31:0]            addr;
   } load_t;

   typedef struct {
      logic [NLINE_WIDTH-1:0] id;
      logic [CL_WIDTH-1:0]    data;
   } line_t;

   stim_t stim_q[$];     // requests still to be offered
   load_t load_q[$];     // accepted loads awaiting their memory request
   line_t exp_lines[$];  // completed lines awaiting refill handshake

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Environment knobs.
   int push_pct   = 100;
   int req_pct    = 100;
   int rsp_pct    = 100;
   int ref_pct    = 100;
   int fixed_last = BEATS - 1;  // beat index carrying last; -1 = random, BEATS = none
   bit seq_data   = 1'b0;

   // Model state.
   bit                     busy;
   bit                     in_txn;
   bit                     err_pend;
   bit                     push_done;
   bit                     rsp_done;
   int                     beat;
   int                     last_pos;
   logic [NLINE_WIDTH-1:0] txn_id;
   logic [CL_WIDTH-1:0]    acc;
   int                     loads_acc = 0;
   int                     err_seen  = 0;
   int                     push_cyc, req_cyc, ref_cyc;
   logic [31:0]            first_req_addr;
   logic [CL_WIDTH-1:0]    first_ref_data;

   task automatic check(input string tag, input logic [CL_WIDTH-1:0] got,
                        input logic [CL_WIDTH-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit roll(input int pct);
      return $urandom_range(99, 0) < pct;
   endfunction

   function automatic logic [31:0] align(input logic [31:0] a);
      return (a / 32'(CL_WIDTH / 8)) * 32'(CL_WIDTH / 8);
   endfunction

   task automatic model_reset();
      stim_q.delete();
      load_q.delete();
      exp_lines.delete();
      busy = 0; in_txn = 0; err_pend = 0; push_done = 0; rsp_done = 0;
      u_memctl_valid  = 1'b0;
      d_mem_req_ready = 1'b0;
      d_mem_rsp_valid = 1'b0;
      d_mem_rsp_last  = 1'b0;
      d_refill_ready  = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_u_ready"},   u_memctl_ready, 1);
      check({tag, "_req_valid"}, d_mem_req_valid, 0);
      check({tag, "_req_addr"},  d_mem_req_addr, 0);
      check({tag, "_rsp_ready"}, d_mem_rsp_ready, 0);
      check({tag, "_ref_valid"}, d_refill_valid, 0);
      check({tag, "_ref_id"},    d_refill_id, 0);
      check({tag, "_ref_data"},  d_refill_data, 0);
      check({tag, "_err"},       err_valid, 0);
   endtask

   task automatic mark_events();
      push_cyc = -1; req_cyc = -1; ref_cyc = -1;
   endtask

   // One clock: observe outputs at negedge, then drive inputs for the next
   // rising edge and advance the model by the handshakes that edge completes.
   task automatic step();
      @(negedge clk);
      cyc++;
      check("err_valid", err_valid, err_pend);
      if (err_valid) err_seen++;
      err_pend = 1'b0;

      if (d_mem_req_valid) begin
         if (req_cyc < 0) begin
            req_cyc = cyc;
            first_req_addr = d_mem_req_addr;
         end
         if (busy || load_q.size() == 0) check("req_spurious", d_mem_req_valid, 0);
         else check("req_addr", d_mem_req_addr, load_q[0].addr);
      end
      if (d_refill_valid) begin
         if (ref_cyc < 0) begin
            ref_cyc = cyc;
            first_ref_data = d_refill_data;
         end
         if (exp_lines.size() == 0) check("refill_spurious", d_refill_valid, 0);
         else begin
            check("refill_id", d_refill_id, exp_lines[0].id);
            check("refill_data", d_refill_data, exp_lines[0].data);
         end
      end

      // Request producer: hold valid and payload until accepted.
      if (push_done) begin
         u_memctl_valid = 1'b0;
         push_done = 1'b0;
      end
      if (!u_memctl_valid && stim_q.size() > 0 && roll(push_pct)) begin
         u_memctl_valid = 1'b1;
         u_memctl_op    = stim_q[0].op;
         u_memctl_id    = stim_q[0].id;
         u_memctl_addr  = stim_q[0].addr;
      end
      if (u_memctl_valid && u_memctl_ready) begin
         if (push_cyc < 0) push_cyc = cyc;
         if (u_memctl_op == MEM_OP_LOAD) begin
            load_q.push_back('{u_memctl_id, align(u_memctl_addr)});
            loads_acc++;
         end else begin
            err_pend = 1'b1;
         end
         void'(stim_q.pop_front());
         push_done = 1'b1;
      end

      // Memory response side: beats in order, last flagged at last_pos.
      if (rsp_done) begin
         d_mem_rsp_valid = 1'b0;
         d_mem_rsp_last  = 1'b0;
         rsp_done = 1'b0;
      end
      if (in_txn && !d_mem_rsp_valid && roll(rsp_pct)) begin
         d_mem_rsp_valid = 1'b1;
         d_mem_rsp_data  = seq_data ? 64'hA + 64'(beat) : {$urandom, $urandom};
         d_mem_rsp_last  = (beat == last_pos);
      end
      if (d_mem_rsp_valid && d_mem_rsp_ready && in_txn) begin
         acc[beat*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = d_mem_rsp_data;
         if (d_mem_rsp_last || beat == BEATS - 1) begin
            if (d_mem_rsp_last != (beat == BEATS - 1)) err_pend = 1'b1;
            exp_lines.push_back('{txn_id, acc});
            in_txn = 1'b0;
         end
         beat++;
         rsp_done = 1'b1;
      end

      // Memory request side.
      d_mem_req_ready = roll(req_pct);
      if (d_mem_req_valid && d_mem_req_ready && !busy && load_q.size() > 0) begin
         txn_id = load_q[0].id;
         void'(load_q.pop_front());
         busy = 1'b1; in_txn = 1'b1; beat = 0; acc = '0;
         if (fixed_last >= 0) last_pos = fixed_last;
         else last_pos = ($urandom_range(3, 0) == 0) ? $urandom_range(BEATS, 0) : BEATS - 1;
      end

      // Refill consumer.
      d_refill_ready = roll(ref_pct);
      if (d_refill_valid && d_refill_ready && exp_lines.size() > 0) begin
         void'(exp_lines.pop_front());
         busy = 1'b0;
      end
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((stim_q.size() > 0 || u_memctl_valid || load_q.size() > 0 || busy) && n < budget) begin
         step();
         n++;
      end
      check("drain_pending", stim_q.size() + load_q.size() + int'(busy), 0);
      repeat (3) step();
   endtask

   task automatic push_load(input logic [NLINE_WIDTH-1:0] id, input logic [31:0] addr);
      stim_q.push_back('{MEM_OP_LOAD, id, addr});
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [CL_WIDTH-1:0] exp_line;
      int base_loads, base_err, n;

      model_reset();
      repeat (3) @(negedge clk);
      check_reset_vals("in_rst");
      rst_n = 1'b1;
      step();
      check_reset_vals("post_rst");

      // Single load with known beats and minimum latency.
      seq_data = 1'b1;
      mark_events();
      push_load(5'h13, 32'h0000_1234);
      drain(100);
      exp_line = {64'hD, 64'hC, 64'hB, 64'hA};
      check("single_addr", first_req_addr, 32'h0000_1220);
      check("single_req_lat", req_cyc - push_cyc, 2);
      check("single_ref_lat", ref_cyc - push_cyc, 7);
      check("single_line", first_ref_data, exp_line);

      // Queue full with memory stalled; a non-load in the stream takes no slot.
      seq_data = 1'b0;
      req_pct = 0;
      base_loads = loads_acc;
      base_err = err_seen;
      push_load(5'h01, 32'h0000_0040);
      push_load(5'h02, 32'h0000_0080);
      stim_q.push_back('{3'h1, 5'h1F, 32'h0000_0100});
      for (int i = 3; i < 8; i++) push_load(5'(i), 32'(i * 32'h100 + 7));
      repeat (15) step();
      check("full_accepted", loads_acc - base_loads, 5);
      check("full_ready", u_memctl_ready, 0);
      check("full_stalled", u_memctl_valid, 1);
      check("full_nonload_err", err_seen - base_err, 1);
      req_pct = 100;
      drain(300);
      check("full_ready_again", u_memctl_ready, 1);

      // Refill backpressure: line held stable, no second memory request.
      ref_pct = 0;
      push_load(5'h0A, 32'hDEAD_BEEF);
      push_load(5'h0B, 32'h1234_5678);
      n = 0;
      while (!d_refill_valid && n < 50) begin
         step();
         n++;
      end
      check("bp_wait_refill", d_refill_valid, 1);
      for (int i = 0; i < 10; i++) begin
         step();
         check("bp_valid", d_refill_valid, 1);
         check("bp_no_req", d_mem_req_valid, 0);
      end
      ref_pct = 100;
      drain(100);

      // Early last on beat 2: slot 3 zero, one error pulse.
      seq_data = 1'b1;
      fixed_last = 2;
      base_err = err_seen;
      mark_events();
      push_load(5'h07, 32'h0000_2000);
      drain(100);
      exp_line = {64'h0, 64'hC, 64'hB, 64'hA};
      check("early_line", first_ref_data, exp_line);
      check("early_err_cnt", err_seen - base_err, 1);
      fixed_last = BEATS - 1;

      // Non-load alone: no request, one error pulse, nothing enqueued.
      base_err = err_seen;
      base_loads = loads_acc;
      mark_events();
      stim_q.push_back('{3'h1, 5'h05, 32'h0000_3000});
      drain(20);
      repeat (5) step();
      check("nonload_no_req", req_cyc, -1);
      check("nonload_err_cnt", err_seen - base_err, 1);
      check("nonload_no_enq", loads_acc - base_loads, 0);
      check("nonload_ready", u_memctl_ready, 1);

      // Reset while collecting beats.
      rsp_pct = 0;
      push_load(5'h11, 32'h0000_4000);
      n = 0;
      while (!d_mem_rsp_ready && n < 20) begin
         step();
         n++;
      end
      check("mid_wait_collect", d_mem_rsp_ready, 1);
      rsp_pct = 100;
      step();
      step();
      rst_n = 1'b0;
      #1;
      check_reset_vals("mid_rst");
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      mark_events();
      push_load(5'h13, 32'h0000_5234);
      drain(100);
      exp_line = {64'hD, 64'hC, 64'hB, 64'hA};
      check("after_rst_addr", first_req_addr, 32'h0000_5220);
      check("after_rst_lat", ref_cyc - push_cyc, 7);
      check("after_rst_line", first_ref_data, exp_line);

      // Randomized traffic with random handshakes and occasional malformed bursts.
      seq_data = 1'b0;
      fixed_last = -1;
      for (int b = 0; b < 4; b++) begin
         push_pct = $urandom_range(100, 30);
         req_pct  = $urandom_range(100, 30);
         rsp_pct  = $urandom_range(100, 30);
         ref_pct  = $urandom_range(100, 30);
         for (int i = 0; i < 50; i++) begin
            stim_q.push_back('{($urandom_range(9, 0) == 0) ? 3'($urandom_range(7, 1)) : MEM_OP_LOAD,
                               5'($urandom), $urandom});
         end
         drain(5000);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
